// File: rtl/register_file_2r2w_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_2r2w_if
//  Description : Bus bundle for the 2-read / 2-write register file.
//                master : decode/writeback side (drives indices, write data,
//                         write enables; receives read data)
//                slave  : the register file itself
//  Signals     : read_index_a/b  [INDEX_WIDTH] read port selects
//                read_data_a/b   [WIDTH]       read port data
//                write_index_a/b [INDEX_WIDTH] write port targets
//                write_data_a/b  [WIDTH]       write port data
//                write_enable_a/b              write port enables
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_file_2r2w_if #(
    parameter int WIDTH       = 16,
    parameter int INDEX_WIDTH = 2
);
    logic [INDEX_WIDTH-1:0] read_index_a;
    logic [WIDTH-1:0]       read_data_a;
    logic [INDEX_WIDTH-1:0] read_index_b;
    logic [WIDTH-1:0]       read_data_b;
    logic [INDEX_WIDTH-1:0] write_index_a;
    logic [WIDTH-1:0]       write_data_a;
    logic                   write_enable_a;
    logic [INDEX_WIDTH-1:0] write_index_b;
    logic [WIDTH-1:0]       write_data_b;
    logic                   write_enable_b;

    modport master (
        output read_index_a, read_index_b,
        output write_index_a, write_data_a, write_enable_a,
        output write_index_b, write_data_b, write_enable_b,
        input  read_data_a, read_data_b
    );

    modport slave (
        input  read_index_a, read_index_b,
        input  write_index_a, write_data_a, write_enable_a,
        input  write_index_b, write_data_b, write_enable_b,
        output read_data_a, read_data_b
    );
endinterface
`default_nettype wire

// File: rtl/register_file_2r2w.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_2r2w
//  Description : Parametrised register file, DEPTH = 2**INDEX_WIDTH entries of
//                WIDTH bits, two combinational read ports and two synchronous
//                write ports. Optional same-cycle write-to-read forwarding
//                (BYPASS) and optional hardwired zero register (ZERO_REG).
//  Ports       : clk    - clock, all state changes on the rising edge
//                reset  - synchronous active-high, clears every register
//                bus    - register_file_2r2w_if.slave (read/write ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_2r2w #(
    parameter int WIDTH       = 16,
    parameter int INDEX_WIDTH = 2,
    parameter bit BYPASS      = 1'b0,
    parameter bit ZERO_REG    = 1'b0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    register_file_2r2w_if.slave  bus
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    logic             w_we_a;
    logic             w_we_b;
    logic [WIDTH-1:0] w_read_a;
    logic [WIDTH-1:0] w_read_b;

    // Writes aimed at the zero register are removed here, so they take no
    // part in collisions or forwarding further down.
    assign w_we_a = bus.write_enable_a && !(ZERO_REG && (bus.write_index_a == '0));
    assign w_we_b = bus.write_enable_b && !(ZERO_REG && (bus.write_index_b == '0));

    // Next-state: port B is applied last so it wins an index collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (w_we_a && (bus.write_index_a == INDEX_WIDTH'(i))) begin
                regs_d[i] = bus.write_data_a;
            end
            if (w_we_b && (bus.write_index_b == INDEX_WIDTH'(i))) begin
                regs_d[i] = bus.write_data_b;
            end
        end
    end

    // Reset takes priority over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port A: stored value, optionally overridden by a pending write
    // (port B first, matching the collision rule). Forwarding is off while
    // reset is high because those writes will never land.
    always_comb begin
        w_read_a = regs_q[bus.read_index_a];
        if (BYPASS && !reset) begin
            if (w_we_b && (bus.write_index_b == bus.read_index_a)) begin
                w_read_a = bus.write_data_b;
            end else if (w_we_a && (bus.write_index_a == bus.read_index_a)) begin
                w_read_a = bus.write_data_a;
            end
        end
        if (ZERO_REG && (bus.read_index_a == '0)) begin
            w_read_a = '0;
        end
    end

    // Read port B: identical selection against read_index_b.
    always_comb begin
        w_read_b = regs_q[bus.read_index_b];
        if (BYPASS && !reset) begin
            if (w_we_b && (bus.write_index_b == bus.read_index_b)) begin
                w_read_b = bus.write_data_b;
            end else if (w_we_a && (bus.write_index_a == bus.read_index_b)) begin
                w_read_b = bus.write_data_a;
            end
        end
        if (ZERO_REG && (bus.read_index_b == '0)) begin
            w_read_b = '0;
        end
    end

    assign bus.read_data_a = w_read_a;
    assign bus.read_data_b = w_read_b;

endmodule
`default_nettype wire

// File: tb/tb_register_file_2r2w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_2r2w
//  Description : Self-checking bench for register_file_2r2w. Three 16x4
//                instances (plain, bypass, bypass+zero-reg) share one
//                directed vector table; a 32x8 instance gets a short
//                hand-written sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_2r2w;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared stimulus for the 16-bit instances
    logic [1:0]  ria, rib, wia, wib;
    logic [15:0] wda, wdb;
    logic        wea, web;

    // stimulus for the 32-bit instance
    logic [2:0]  xria, xrib, xwia, xwib;
    logic [31:0] xwda, xwdb;
    logic        xwea, xweb;

    register_file_2r2w_if #(.WIDTH(16), .INDEX_WIDTH(2)) if_base ();
    register_file_2r2w_if #(.WIDTH(16), .INDEX_WIDTH(2)) if_byp  ();
    register_file_2r2w_if #(.WIDTH(16), .INDEX_WIDTH(2)) if_zero ();
    register_file_2r2w_if #(.WIDTH(32), .INDEX_WIDTH(3)) if_wide ();

    assign if_base.read_index_a = ria;  assign if_base.read_index_b = rib;
    assign if_base.write_index_a = wia; assign if_base.write_data_a = wda;
    assign if_base.write_enable_a = wea;
    assign if_base.write_index_b = wib; assign if_base.write_data_b = wdb;
    assign if_base.write_enable_b = web;

    assign if_byp.read_index_a = ria;   assign if_byp.read_index_b = rib;
    assign if_byp.write_index_a = wia;  assign if_byp.write_data_a = wda;
    assign if_byp.write_enable_a = wea;
    assign if_byp.write_index_b = wib;  assign if_byp.write_data_b = wdb;
    assign if_byp.write_enable_b = web;

    assign if_zero.read_index_a = ria;  assign if_zero.read_index_b = rib;
    assign if_zero.write_index_a = wia; assign if_zero.write_data_a = wda;
    assign if_zero.write_enable_a = wea;
    assign if_zero.write_index_b = wib; assign if_zero.write_data_b = wdb;
    assign if_zero.write_enable_b = web;

    assign if_wide.read_index_a = xria;  assign if_wide.read_index_b = xrib;
    assign if_wide.write_index_a = xwia; assign if_wide.write_data_a = xwda;
    assign if_wide.write_enable_a = xwea;
    assign if_wide.write_index_b = xwib; assign if_wide.write_data_b = xwdb;
    assign if_wide.write_enable_b = xweb;

    register_file_2r2w #(.WIDTH(16), .INDEX_WIDTH(2), .BYPASS(1'b0), .ZERO_REG(1'b0))
        u_base (.clk(clk), .reset(rst), .bus(if_base));
    register_file_2r2w #(.WIDTH(16), .INDEX_WIDTH(2), .BYPASS(1'b1), .ZERO_REG(1'b0))
        u_byp  (.clk(clk), .reset(rst), .bus(if_byp));
    register_file_2r2w #(.WIDTH(16), .INDEX_WIDTH(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
        u_zero (.clk(clk), .reset(rst), .bus(if_zero));
    register_file_2r2w #(.WIDTH(32), .INDEX_WIDTH(3), .BYPASS(1'b0), .ZERO_REG(1'b0))
        u_wide (.clk(clk), .reset(rst), .bus(if_wide));

    // One row = inputs held for one cycle, expected read data sampled just
    // before the closing edge, for plain (0), bypass (1), bypass+zero (2).
    typedef struct packed {
        logic        chk;
        logic        rst;
        logic        wea;
        logic [1:0]  wia;
        logic [15:0] wda;
        logic        web;
        logic [1:0]  wib;
        logic [15:0] wdb;
        logic [1:0]  ria;
        logic [1:0]  rib;
        logic [5:0][15:0] ex;   // {a0,b0,a1,b1,a2,b2}, a0 in [5]
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic chk, input logic r,
        input logic ea, input logic [1:0] ia, input logic [15:0] da,
        input logic eb, input logic [1:0] ib, input logic [15:0] db,
        input logic [1:0] ra, input logic [1:0] rb,
        input logic [15:0] a0, input logic [15:0] b0,
        input logic [15:0] a1, input logic [15:0] b1,
        input logic [15:0] a2, input logic [15:0] b2);
        vec_t v;
        v.chk = chk; v.rst = r;
        v.wea = ea; v.wia = ia; v.wda = da;
        v.web = eb; v.wib = ib; v.wdb = db;
        v.ria = ra; v.rib = rb;
        v.ex  = {a0, b0, a1, b1, a2, b2};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //               chk rst  wea wia wda      web wib wdb      ria rib   a0       b0       a1       b1       a2       b2
        // reset with a pending write; stored state unknown before the edge
        vecs.push_back(mk(0, 1,  1, 2, 16'h0055, 0, 0, 16'h0000, 2, 0,  16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0,  16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3,  16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0));
        // dual write r1=7 / r2=9
        vecs.push_back(mk(1, 0,  1, 1, 16'h0007, 1, 2, 16'h0009, 1, 2,  16'h0,   16'h0,   16'h7,   16'h9,   16'h7,   16'h9));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2,  16'h7,   16'h9,   16'h7,   16'h9,   16'h7,   16'h9));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1,  16'h7,   16'h7,   16'h7,   16'h7,   16'h7,   16'h7));
        // collision on r3, port B wins
        vecs.push_back(mk(1, 0,  1, 3, 16'h1111, 1, 3, 16'h2222, 3, 1,  16'h0,   16'h7,   16'h2222, 16'h7,  16'h2222, 16'h7));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 3, 3,  16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h2222));
        // r0=3 (dropped on zero-reg instance)
        vecs.push_back(mk(1, 0,  1, 0, 16'h0003, 0, 0, 16'h0000, 0, 3,  16'h0,   16'h2222, 16'h3,   16'h2222, 16'h0,   16'h2222));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2,  16'h3,   16'h9,   16'h3,   16'h9,   16'h0,   16'h9));
        // r0=10 pending: old value without bypass, new value with bypass
        vecs.push_back(mk(1, 0,  1, 0, 16'h000A, 0, 0, 16'h0000, 0, 0,  16'h3,   16'h3,   16'hA,   16'hA,   16'h0,   16'h0));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,  16'hA,   16'h7,   16'hA,   16'h7,   16'h0,   16'h7));
        // B writes index 0 = FFFF while A writes r1=4
        vecs.push_back(mk(1, 0,  1, 1, 16'h0004, 1, 0, 16'hFFFF, 0, 1,  16'hA,   16'h7,   16'hFFFF, 16'h4,  16'h0,   16'h4));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,  16'hFFFF, 16'h4,  16'hFFFF, 16'h4,  16'h0,   16'h4));
        // reset with pending write: forwarding suppressed, write lost
        vecs.push_back(mk(1, 1,  1, 0, 16'h1234, 0, 0, 16'h0000, 0, 3,  16'hFFFF, 16'h2222, 16'hFFFF, 16'h2222, 16'h0, 16'h2222));
        // first edge after reset accepts writes again
        vecs.push_back(mk(1, 0,  1, 3, 16'h5A5A, 0, 0, 16'h0000, 3, 0,  16'h0,   16'h0,   16'h5A5A, 16'h0,  16'h5A5A, 16'h0));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 3, 2,  16'h5A5A, 16'h0,  16'h5A5A, 16'h0,  16'h5A5A, 16'h0));
        // port B disabled on same index: only A data lands / forwards
        vecs.push_back(mk(1, 0,  1, 2, 16'h0BAD, 0, 2, 16'hCAFE, 2, 2,  16'h0,   16'h0,   16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD));
        vecs.push_back(mk(1, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3,  16'h0BAD, 16'h5A5A, 16'h0BAD, 16'h5A5A, 16'h0BAD, 16'h5A5A));

        xria = '0; xrib = '0; xwia = '0; xwib = '0;
        xwda = '0; xwdb = '0; xwea = 1'b0; xweb = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            wea = vecs[i].wea; wia = vecs[i].wia; wda = vecs[i].wda;
            web = vecs[i].web; wib = vecs[i].wib; wdb = vecs[i].wdb;
            ria = vecs[i].ria; rib = vecs[i].rib;
            #3;
            if (vecs[i].chk) begin
                check($sformatf("v%0d plain A", i),  {16'h0, if_base.read_data_a}, {16'h0, vecs[i].ex[5]});
                check($sformatf("v%0d plain B", i),  {16'h0, if_base.read_data_b}, {16'h0, vecs[i].ex[4]});
                check($sformatf("v%0d bypass A", i), {16'h0, if_byp.read_data_a},  {16'h0, vecs[i].ex[3]});
                check($sformatf("v%0d bypass B", i), {16'h0, if_byp.read_data_b},  {16'h0, vecs[i].ex[2]});
                check($sformatf("v%0d zero A", i),   {16'h0, if_zero.read_data_a}, {16'h0, vecs[i].ex[1]});
                check($sformatf("v%0d zero B", i),   {16'h0, if_zero.read_data_b}, {16'h0, vecs[i].ex[0]});
            end
            @(posedge clk);
            #1;
        end
        wea = 1'b0; web = 1'b0; rst = 1'b0;

        // Wide instance was cleared by the resets in the table.
        xria = 3'd7; xrib = 3'd7;
        #1;
        check("wide r7 after reset A", if_wide.read_data_a, 32'h0);
        check("wide r7 after reset B", if_wide.read_data_b, 32'h0);
        xwea = 1'b1; xwia = 3'd7; xwda = 32'hDEADBEEF;
        #1;
        check("wide r7 pending no bypass", if_wide.read_data_a, 32'h0);
        @(posedge clk);
        #1;
        xwea = 1'b0;
        for (int r = 0; r < 8; r++) begin
            xria = 3'(r);
            xrib = 3'(r);
            #1;
            check($sformatf("wide r%0d A", r), if_wide.read_data_a, (r == 7) ? 32'hDEADBEEF : 32'h0);
            check($sformatf("wide r%0d B", r), if_wide.read_data_b, (r == 7) ? 32'hDEADBEEF : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
